// File: rtl/elastic_pipeline_pkg.sv
// Shared definitions for the elastic pipeline: occupancy width helper and
// the per-stage storage type (valid flag plus data word).
package elastic_pipeline_pkg;

  // Width of a counter able to hold 0..stages inclusive.
  function automatic int occ_width(input int stages);
    if (stages < 1) begin
      return 1;
    end else begin
      return $clog2(stages + 1);
    end
  endfunction

  // Parameterised typedef holder: stage_type#(.W(n))::stage_t is the
  // storage of one stage for an n-bit word.
  virtual class stage_type #(parameter int W = 16);
    typedef struct packed {
      logic         valid;
      logic [W-1:0] data;
    } stage_t;
  endclass

endpackage

// File: rtl/elastic_pipeline_pipe_stage.sv
// One register slot of the elastic pipeline. The slot takes a new word
// (or a bubble) from upstream whenever it is empty or its own word moves
// downstream on the same edge; "advance" tells upstream that it may move.
module pipe_stage
  import elastic_pipeline_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            up_valid,
  input  logic [BITS-1:0] up_data,
  input  logic            down_advance,
  output logic            valid,
  output logic [BITS-1:0] data,
  output logic            advance
);

  typedef stage_type#(.W(BITS))::stage_t stage_t;

  stage_t stage_q;
  stage_t stage_d;

  // Slot can take a word when empty or when its occupant leaves this edge.
  always_comb begin
    advance = (!stage_q.valid) || down_advance;
  end

  // Next slot contents: reset beats flush, flush beats any load.
  always_comb begin
    stage_d = stage_q;
    if (reset) begin
      stage_d.valid = 1'b0;
      stage_d.data  = {BITS{1'b0}};
    end else if (flush) begin
      stage_d.valid = 1'b0;
      stage_d.data  = stage_q.data;
    end else if (advance) begin
      stage_d.valid = up_valid;
      if (up_valid) begin
        stage_d.data = up_data;
      end else begin
        stage_d.data = stage_q.data;
      end
    end else begin
      stage_d = stage_q;
    end
  end

  // Slot register.
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign valid = stage_q.valid;
  assign data  = stage_q.data;

endmodule

// File: rtl/elastic_pipeline.sv
// Elastic pipeline of STAGES register slots with valid/ready handshakes on
// both sides. Bubbles collapse, so an empty slot anywhere downstream lets
// earlier words move even while the output is stalled. The output word is
// taken straight from the last slot.
module elastic_pipeline
  import elastic_pipeline_pkg::*;
#(
  parameter int BITS   = 16,
  parameter int STAGES = 5
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           flush_in,
  input  logic                           valid_in,
  input  logic [BITS-1:0]                data_in,
  output logic                           ready_out,
  output logic                           valid_out,
  output logic [BITS-1:0]                data_out,
  input  logic                           ready_in,
  output logic [occ_width(STAGES)-1:0]   occupancy_out
);

  localparam int OCC_W = occ_width(STAGES);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1'b1);
  localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(1'b0);

  logic             in_fire_s;
  logic             out_fire_s;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Slot chain: slot i feeds slot i+1; the ready (advance) chain runs from
  // ready_in back through every slot to the input side.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic            up_valid_s;
    logic [BITS-1:0] up_data_s;
    logic            down_adv_s;
    logic            valid_s;
    logic [BITS-1:0] data_s;
    logic            adv_s;

    if (i == 0) begin : g_head
      assign up_valid_s = valid_in;
      assign up_data_s  = data_in;
    end else begin : g_link
      assign up_valid_s = g_stage[i-1].valid_s;
      assign up_data_s  = g_stage[i-1].data_s;
    end

    if (i == STAGES - 1) begin : g_tail
      assign down_adv_s = ready_in;
    end else begin : g_mid
      assign down_adv_s = g_stage[i+1].adv_s;
    end

    pipe_stage #(
      .BITS(BITS)
    ) u_stage (
      .clk          (clk_in),
      .reset        (rst_in),
      .flush        (flush_in),
      .up_valid     (up_valid_s),
      .up_data      (up_data_s),
      .down_advance (down_adv_s),
      .valid        (valid_s),
      .data         (data_s),
      .advance      (adv_s)
    );
  end

  // Handshake outputs; reset and flush both close the input side.
  always_comb begin
    ready_out  = (!rst_in) && (!flush_in) && g_stage[0].adv_s;
    valid_out  = (!rst_in) && g_stage[STAGES-1].valid_s;
    data_out   = g_stage[STAGES-1].data_s;
    in_fire_s  = valid_in && ready_out;
    out_fire_s = valid_out && ready_in;
  end

  // Occupancy moves only with transfers, since bubbles never change the count.
  always_comb begin
    occ_d = occ_q;
    if (rst_in) begin
      occ_d = OCC_ZERO;
    end else if (flush_in) begin
      occ_d = OCC_ZERO;
    end else begin
      case ({in_fire_s, out_fire_s})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk_in) begin
    occ_q <= occ_d;
  end

  assign occupancy_out = occ_q;

endmodule

// File: tb/tb_elastic_pipeline.sv
// Self-checking bench for elastic_pipeline (BITS=16, STAGES=5). The reference
// model keeps the in-flight words as an ordered list with a slot position per
// word; each edge a word steps forward when a free slot exists ahead of it
// or the output is accepting.
module tb_elastic_pipeline;

  localparam int BITS   = 16;
  localparam int STAGES = 5;

  logic            clk = 1'b0;
  logic            rst_in;
  logic            flush_in;
  logic            valid_in;
  logic [BITS-1:0] data_in;
  logic            ready_out;
  logic            valid_out;
  logic [BITS-1:0] data_out;
  logic            ready_in;
  logic [2:0]      occupancy_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [BITS-1:0] m_data[$];
  int              m_pos[$];
  bit              model_known = 1'b0;
  bit              seen_1234   = 1'b0;

  always #5 clk = ~clk;

  elastic_pipeline #(
    .BITS  (BITS),
    .STAGES(STAGES)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst_in),
    .flush_in     (flush_in),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .ready_out    (ready_out),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .ready_in     (ready_in),
    .occupancy_out(occupancy_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return !rst_in && !flush_in && ((m_data.size() < STAGES) || ready_in);
  endfunction

  function automatic bit exp_valid();
    return !rst_in && (m_data.size() > 0) && (m_pos[0] == STAGES - 1);
  endfunction

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare_all();
    if (valid_out === 1'b1 && data_out === 16'h1234) seen_1234 = 1'b1;
    if (model_known) begin
      chk("ready_out", {31'd0, ready_out}, {31'd0, exp_ready()});
      chk("valid_out", {31'd0, valid_out}, {31'd0, exp_valid()});
      if (exp_valid()) chk("data_out", {16'd0, data_out}, {16'd0, m_data[0]});
      chk("occupancy", {29'd0, occupancy_out}, m_data.size());
    end
  endtask

  // Advance the model across one rising edge using the held inputs.
  task automatic model_step();
    bit rdy;
    bit outx;
    rdy  = exp_ready();
    outx = exp_valid() && ready_in;
    if (rst_in) begin
      m_data.delete();
      m_pos.delete();
      model_known = 1'b1;
    end else if (model_known) begin
      if (flush_in) begin
        m_data.delete();
        m_pos.delete();
      end else begin
        for (int k = 0; k < m_data.size(); k++) begin
          if (ready_in || (k + 1 < STAGES - m_pos[k])) m_pos[k] = m_pos[k] + 1;
        end
        if (outx) begin
          void'(m_data.pop_front());
          void'(m_pos.pop_front());
        end
        if (valid_in && rdy) begin
          m_data.push_back(data_in);
          m_pos.push_back(0);
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [BITS-1:0] d, input logic r,
                      input logic f, input logic rs);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    ready_in = r;
    flush_in = f;
    rst_in   = rs;
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst_in   = 1'b1;
    flush_in = 1'b0;
    valid_in = 1'b0;
    data_in  = 16'h0000;
    ready_in = 1'b0;

    // Reset state
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("rst_occ", {29'd0, occupancy_out}, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_ready", {31'd0, ready_out}, 32'd0);

    // Streaming 0x0001..0x0014 with ready_in high
    for (int w = 1; w <= 20; w++) begin
      step(1'b1, BITS'(w), 1'b1, 1'b0, 1'b0);
      if (w == 4) chk("stream_lat_early", {31'd0, valid_out}, 32'd0);
      if (w == 5) begin
        chk("stream_lat_valid", {31'd0, valid_out}, 32'd1);
        chk("stream_first", {16'd0, data_out}, 32'h0001);
      end
    end
    chk("stream_w16", {16'd0, data_out}, 32'h0010);
    repeat (6) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("stream_empty", {29'd0, occupancy_out}, 32'd0);

    // Backpressure: 7 offered, 5 accepted
    for (int w = 0; w < 7; w++) step(1'b1, 16'h0100 + BITS'(w), 1'b0, 1'b0, 1'b0);
    chk("bp_occ", {29'd0, occupancy_out}, 32'd5);
    chk("bp_ready", {31'd0, ready_out}, 32'd0);
    chk("bp_head", {16'd0, data_out}, 32'h0100);
    repeat (2) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("bp_stable", {16'd0, data_out}, 32'h0100);
    for (int j = 0; j < 5; j++) begin
      chk("bp_drain", {16'd0, data_out}, 32'h0100 + j);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    end
    chk("bp_empty", {29'd0, occupancy_out}, 32'd0);

    // Bubble collapse under a stalled output
    step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("bub_occ", {29'd0, occupancy_out}, 32'd2);
    chk("bub_head", {16'd0, data_out}, 32'hAAAA);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("bub_adjacent_valid", {31'd0, valid_out}, 32'd1);
    chk("bub_adjacent_data", {16'd0, data_out}, 32'hBBBB);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("bub_empty", {31'd0, valid_out}, 32'd0);

    // Flush with 4 words in flight and a word offered on the flush edge
    seen_1234 = 1'b0;
    for (int w = 0; w < 4; w++) step(1'b1, 16'h0200 + BITS'(w), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b0, 1'b1, 1'b0);
    chk("flush_occ", {29'd0, occupancy_out}, 32'd0);
    chk("flush_valid", {31'd0, valid_out}, 32'd0);
    repeat (8) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("flush_no_1234", {31'd0, seen_1234}, 32'd0);

    // Reset mid-stream, then full latency for the next word
    for (int w = 0; w < 3; w++) step(1'b1, 16'h0300 + BITS'(w), 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("mrst_occ", {29'd0, occupancy_out}, 32'd0);
    chk("mrst_data", {16'd0, data_out}, 32'h0000);
    step(1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("mrst_lat_early", {31'd0, valid_out}, 32'd0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("mrst_lat_valid", {31'd0, valid_out}, 32'd1);
    chk("mrst_word", {16'd0, data_out}, 32'h5A5A);

    // Random stress against the model
    for (int c = 0; c < 10000; c++) begin
      step($urandom_range(0, 3) != 0, BITS'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 127) == 0, $urandom_range(0, 1023) == 0);
    end
    repeat (8) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("final_empty", {29'd0, occupancy_out}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
